// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Per-register countdown scoreboard; stalls decode on RAW/WAW
//            hazards and squashes entries recorded in the last few issue
//            cycles when a taken branch resolves.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NREG        = 32,
    parameter int REG_AW      = 5,
    parameter int MAX_LAT     = 4,
    parameter int LAT_W       = 3,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic              wr_rd,
    input  logic [LAT_W-1:0]  lat,
    input  logic              flush,
    output logic              stall,
    output logic              issue_fire,
    output logic [NREG-1:0]   pending,
    output logic [REG_AW:0]   busy_cnt
);

    localparam int               AGE_W      = (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1);
    localparam logic [AGE_W-1:0] C_AGE_SAT  = AGE_W'(FLUSH_DEPTH);
    localparam logic [LAT_W-1:0] C_MAX_LAT  = LAT_W'(MAX_LAT);
    localparam int               C_IDX_SPAN = 2 ** REG_AW;

    logic [LAT_W-1:0]      r_cnt [NREG];
    logic [AGE_W-1:0]      r_age [NREG];
    logic [NREG-1:0]       r_pending;
    logic [REG_AW:0]       r_busy_cnt;

    logic [LAT_W-1:0]      w_cnt_nxt [NREG];
    logic [AGE_W-1:0]      w_age_nxt [NREG];
    logic [NREG-1:0]       w_pending_nxt;
    logic [REG_AW:0]       w_busy_nxt;
    logic [C_IDX_SPAN-1:0] w_pend_ext;
    logic [LAT_W-1:0]      w_lat_eff;
    logic                  w_raw;
    logic                  w_waw;
    logic                  w_stall;
    logic                  w_fire;
    logic                  w_record;

    // Widen the pending vector to the full index space so any rs/rd lookup is defined.
    always_comb begin
        w_pend_ext = '0;
        for (int i = 0; i < NREG; i++) begin
            w_pend_ext[i] = r_pending[i];
        end
    end

    always_comb begin
        w_raw     = (use_rs1 && (rs1 != '0) && w_pend_ext[rs1]) ||
                    (use_rs2 && (rs2 != '0) && w_pend_ext[rs2]);
        w_waw     = wr_rd && (rd != '0) && w_pend_ext[rd];
        w_stall   = issue_valid && (w_raw || w_waw) && !flush;
        w_fire    = issue_valid && !w_stall && !flush;
        w_lat_eff = (lat > C_MAX_LAT) ? C_MAX_LAT : lat;
        w_record  = w_fire && wr_rd && (rd != '0) && (lat != '0);
    end

    // Next state per entry: decrement, then flush squash, then a new record wins.
    always_comb begin
        w_pending_nxt = '0;
        w_busy_nxt    = '0;
        for (int i = 0; i < NREG; i++) begin
            w_cnt_nxt[i] = (r_cnt[i] != '0) ? (r_cnt[i] - 1'b1) : '0;
            w_age_nxt[i] = (r_age[i] >= C_AGE_SAT) ? C_AGE_SAT : (r_age[i] + 1'b1);
            if (flush && (r_age[i] < C_AGE_SAT)) begin
                w_cnt_nxt[i] = '0;
            end
            if (w_record && (rd == REG_AW'(i))) begin
                w_cnt_nxt[i] = w_lat_eff;
                w_age_nxt[i] = '0;
            end
            w_pending_nxt[i] = (w_cnt_nxt[i] != '0);
            w_busy_nxt       = w_busy_nxt + (REG_AW + 1)'(w_pending_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
                r_age[i] <= C_AGE_SAT;
            end
            r_pending  <= '0;
            r_busy_cnt <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                r_age[i] <= w_age_nxt[i];
            end
            r_pending  <= w_pending_nxt;
            r_busy_cnt <= w_busy_nxt;
        end
    end

    assign stall      = w_stall;
    assign issue_fire = w_fire;
    assign pending    = r_pending;
    assign busy_cnt   = r_busy_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Randomized and directed stimulus against a timestamp-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NREG        = 32;
    localparam int REG_AW      = 5;
    localparam int MAX_LAT     = 4;
    localparam int LAT_W       = 3;
    localparam int FLUSH_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              issue_valid = 1'b0;
    logic [REG_AW-1:0] rs1 = '0;
    logic [REG_AW-1:0] rs2 = '0;
    logic [REG_AW-1:0] rd = '0;
    logic              use_rs1 = 1'b0;
    logic              use_rs2 = 1'b0;
    logic              wr_rd = 1'b0;
    logic [LAT_W-1:0]  lat = '0;
    logic              flush = 1'b0;
    logic              stall;
    logic              issue_fire;
    logic [NREG-1:0]   pending;
    logic [REG_AW:0]   busy_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a register is pending in cycle c while c < ready_cyc; issue_cyc is its last load.
    int cyc = 0;
    int ready_cyc [NREG];
    int issue_cyc [NREG];

    hazard_scoreboard #(
        .NREG(NREG), .REG_AW(REG_AW), .MAX_LAT(MAX_LAT),
        .LAT_W(LAT_W), .FLUSH_DEPTH(FLUSH_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .wr_rd(wr_rd),
        .lat(lat), .flush(flush), .stall(stall), .issue_fire(issue_fire),
        .pending(pending), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [NREG-1:0] model_pending();
        logic [NREG-1:0] v = '0;
        for (int r = 1; r < NREG; r++) v[r] = (cyc < ready_cyc[r]);
        return v;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            ready_cyc[r] = 0;
            issue_cyc[r] = -1000000;
        end
    endtask

    task automatic step(input logic v, input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b,
                        input logic [REG_AW-1:0] d, input logic u1, input logic u2,
                        input logic w, input logic [LAT_W-1:0] l, input logic f);
        logic [NREG-1:0] pv;
        logic            raw, waw, exp_stall, exp_fire;
        int              eff;
        @(negedge clk);
        issue_valid = v; rs1 = a; rs2 = b; rd = d;
        use_rs1 = u1; use_rs2 = u2; wr_rd = w; lat = l; flush = f;
        #1;
        pv        = model_pending();
        raw       = (u1 && a != 0 && pv[a]) || (u2 && b != 0 && pv[b]);
        waw       = w && d != 0 && pv[d];
        exp_stall = v && (raw || waw) && !f;
        exp_fire  = v && !exp_stall && !f;
        check_value("stall", 64'(stall), 64'(exp_stall));
        check_value("issue_fire", 64'(issue_fire), 64'(exp_fire));
        check_value("pending", 64'(pending), 64'(pv));
        check_value("busy_cnt", 64'(busy_cnt), 64'($countones(pv)));
        @(posedge clk);
        if (exp_fire && w && d != 0 && l != 0) begin
            eff          = (int'(l) > MAX_LAT) ? MAX_LAT : int'(l);
            ready_cyc[d] = cyc + 1 + eff;
            issue_cyc[d] = cyc;
        end
        if (f) begin
            for (int r = 0; r < NREG; r++)
                if (cyc - issue_cyc[r] <= FLUSH_DEPTH) ready_cyc[r] = 0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_value("reset_pending", 64'(pending), 64'd0);
        check_value("reset_busy", 64'(busy_cnt), 64'd0);
        check_value("reset_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Producer rd=5 lat=3, dependent on rs1=5 held for four cycles.
        step(1, 0, 0, 5, 0, 0, 1, 3, 0);
        repeat (4) step(1, 5, 0, 0, 1, 0, 0, 0, 0);
        idle(2);
        // Writes to x0 never become pending.
        step(1, 0, 0, 0, 0, 0, 1, 4, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        // WAW on rd=7, then reload.
        step(1, 0, 0, 7, 0, 0, 1, 2, 0);
        repeat (3) step(1, 0, 0, 7, 0, 0, 1, 2, 0);
        idle(3);
        // Three producers then a flush squashing the two youngest.
        step(1, 0, 0, 3, 0, 0, 1, 4, 0);
        step(1, 0, 0, 4, 0, 0, 1, 4, 0);
        step(1, 0, 0, 6, 0, 0, 1, 4, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        // Flush together with a valid producer: nothing recorded.
        step(1, 0, 0, 9, 0, 0, 1, 2, 1);
        idle(2);
        // Latency above the limit is clamped.
        step(1, 0, 0, 12, 0, 0, 1, 7, 0);
        idle(6);

        // Asynchronous reset while three entries are busy.
        step(1, 0, 0, 10, 0, 0, 1, 4, 0);
        step(1, 0, 0, 11, 0, 0, 1, 4, 0);
        step(1, 0, 0, 13, 0, 0, 1, 4, 0);
        @(negedge clk);
        issue_valid = 1'b0; flush = 1'b0;
        #1;
        check_value("busy_before_rst", 64'(busy_cnt), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        check_value("async_rst_pending", 64'(pending), 64'd0);
        check_value("async_rst_busy", 64'(busy_cnt), 64'd0);
        check_value("async_rst_stall", 64'(stall), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_clear();

        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 3) != 0),
                 REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7)),
                 REG_AW'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) != 0),
                 LAT_W'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
